// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   Execute stage between register-file read and writeback. It accepts RV32I
//   operands and an op selector under a valid/ready handshake. ADD/SUB/SLT/
//   SLTU/XOR/OR/AND finish in one cycle. SLL/SRL/SRA run on an iterative
//   shifter that moves SHIFT_PER_CYCLE bits per cycle. The result stays
//   registered until the writeback side takes it.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   operands/op valid
//   in_ready   out  1   stage can accept this cycle
//   op         in   4   {funct7[5], funct3}
//   in0        in   32  operand A (rs1)
//   in1        in   32  operand B (rs2 or imm); shift amount is in1[4:0]
//   out_valid  out  1   result valid
//   out_ready  in   1   downstream accepts result
//   out        out  32  result
//   illegal    out  1   op code not recognised; qualified by out_valid
//   busy       out  1   high while the iterative shifter is running
//
// Parameter
//   SHIFT_PER_CYCLE  bits shifted per SHIFT cycle; a power of 2 from 1 to 32

module alu_exec_stage #(
  parameter int SHIFT_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        illegal,
  output logic        busy
);

  typedef enum logic {IDLE, SHIFT} state_t;
  typedef enum logic [1:0] {K_SLL, K_SRL, K_SRA} shift_kind_t;

  localparam logic [5:0] STEP = 6'(SHIFT_PER_CYCLE);

  state_t      r_state, w_next_state;
  shift_kind_t r_kind, w_next_kind, w_kind;
  logic [31:0] r_acc, w_next_acc;
  logic [5:0]  r_cnt, w_next_cnt;
  logic [31:0] r_out, w_next_out;
  logic        r_illegal, w_next_illegal;
  logic        r_out_valid, w_next_out_valid;

  logic [31:0] w_alu_res;
  logic        w_alu_ill;
  logic        w_is_shift;
  logic [4:0]  w_shamt;
  logic [5:0]  w_step;
  logic [31:0] w_shifted;
  logic        w_accept;

  assign w_shamt  = in1[4:0];
  assign in_ready = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign illegal   = r_illegal;
  assign busy      = (r_state == SHIFT);

  // Single-cycle result. For shift ops this is the shamt==0 result (in0).
  // When shamt is nonzero, the value is ignored and the shifter takes over.
  always_comb begin
    w_alu_res  = '0;
    w_alu_ill  = 1'b0;
    w_is_shift = 1'b0;
    w_kind     = K_SLL;
    case (op)
      4'b0000: w_alu_res = in0 + in1;
      4'b1000: w_alu_res = in0 - in1;
      4'b0010: w_alu_res = {31'b0, $signed(in0) < $signed(in1)};
      4'b0011: w_alu_res = {31'b0, in0 < in1};
      4'b0100: w_alu_res = in0 ^ in1;
      4'b0110: w_alu_res = in0 | in1;
      4'b0111: w_alu_res = in0 & in1;
      4'b0001: begin
        w_alu_res  = in0;
        w_is_shift = 1'b1;
        w_kind     = K_SLL;
      end
      4'b0101: begin
        w_alu_res  = in0;
        w_is_shift = 1'b1;
        w_kind     = K_SRL;
      end
      4'b1101: begin
        w_alu_res  = in0;
        w_is_shift = 1'b1;
        w_kind     = K_SRA;
      end
      default: w_alu_ill = 1'b1;
    endcase
  end

  // The final step may be shorter than SHIFT_PER_CYCLE.
  // An arithmetic shift of acc repeats acc[31]. That bit never changes during
  // SRA, so the fill stays the sign bit that acc had on entry.
  always_comb begin
    w_step = (r_cnt < STEP) ? r_cnt : STEP;
    case (r_kind)
      K_SLL:   w_shifted = r_acc << w_step;
      K_SRL:   w_shifted = r_acc >> w_step;
      K_SRA:   w_shifted = $signed(r_acc) >>> w_step;
      default: w_shifted = r_acc;
    endcase
  end

  // Next-state logic. A held result is kept unless it transfers.
  // A new load on the same edge as a transfer keeps out_valid high.
  always_comb begin
    w_next_state     = r_state;
    w_next_kind      = r_kind;
    w_next_acc       = r_acc;
    w_next_cnt       = r_cnt;
    w_next_out       = r_out;
    w_next_illegal   = r_illegal;
    w_next_out_valid = r_out_valid && !out_ready;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_shift && (w_shamt != 5'd0)) begin
            w_next_state = SHIFT;
            w_next_acc   = in0;
            w_next_cnt   = {1'b0, w_shamt};
            w_next_kind  = w_kind;
          end else begin
            w_next_out       = w_alu_res;
            w_next_illegal   = w_alu_ill;
            w_next_out_valid = 1'b1;
          end
        end
      end
      SHIFT: begin
        w_next_acc = w_shifted;
        w_next_cnt = r_cnt - w_step;
        if (r_cnt == w_step) begin
          w_next_state     = IDLE;
          w_next_out       = w_shifted;
          w_next_illegal   = 1'b0;
          w_next_out_valid = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Reset discards any in-flight shift and any held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_kind      <= K_SLL;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_kind      <= w_next_kind;
      r_acc       <= w_next_acc;
      r_cnt       <= w_next_cnt;
      r_out       <= w_next_out;
      r_illegal   <= w_next_illegal;
      r_out_valid <= w_next_out_valid;
    end
  end

endmodule
